// File: rtl/slave_port_serial.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_serial
// Purpose  : Serial bus slave port; deserialises address/write data, drives a
//            one-cycle-latency memory and serialises read data back out.
// Revision : 1.0  initial release
// ============================================================================
module slave_port_serial #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_MEMWR = 3'd3,
        S_MEMRD = 3'd4,
        S_RWAIT = 3'd5,
        S_RDATA = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rsh_q, rsh_d;
    logic                    mode_q, mode_d;
    logic                    svalid_q, svalid_d;
    logic                    sready_q, sready_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rsh_d   = rsh_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (mvalid) begin
                    addr_d  = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    mode_d  = smode;
                    cnt_d   = CNT_ONE;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mvalid) begin
                    addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = mode_q ? S_WDATA : S_MEMRD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_WDATA: begin
                if (mvalid) begin
                    wdata_d = {swdata, wdata_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_MEMWR;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_MEMWR: state_d = S_IDLE;
            S_MEMRD: state_d = S_RWAIT;
            S_RWAIT: begin
                rsh_d   = mem_rdata;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                // zero fill keeps srdata low once the word has been shifted out
                rsh_d = {1'b0, rsh_q[DATA_WIDTH-1:1]};
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // sready lags one extra cycle after a write so the strobe cycle is fully retired
    always_comb begin
        svalid_d = (state_d == S_RDATA);
        wen_d    = (state_d == S_MEMWR);
        ren_d    = (state_d == S_MEMRD);
        sready_d = (state_d == S_IDLE) && (state_q != S_MEMWR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsh_q    <= '0;
            mode_q   <= 1'b0;
            svalid_q <= 1'b0;
            sready_q <= 1'b1;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rsh_q    <= rsh_d;
            mode_q   <= mode_d;
            svalid_q <= svalid_d;
            sready_q <= sready_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
        end
    end

    assign srdata    = rsh_q[0];
    assign svalid    = svalid_q;
    assign sready    = sready_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wen   = wen_q;
    assign mem_ren   = ren_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_port_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_port_serial
// Purpose  : Directed self-checking bench for slave_port_serial.
// Revision : 1.0  initial release
// ============================================================================
module tb_slave_port_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swdata = 1'b0;
    logic        smode = 1'b0;
    logic        mvalid = 1'b0;
    logic        srdata;
    logic        svalid;
    logic        sready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    slave_port_serial #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .swdata    (swdata),
        .smode     (smode),
        .mvalid    (mvalid),
        .srdata    (srdata),
        .svalid    (svalid),
        .sready    (sready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with a bench-side preload port
    logic [7:0]  mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'h000;
    logic [7:0]  pl_data = 8'h00;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    // Monitor, sampled on the falling edge
    int         wen_cnt = 0, ren_cnt = 0, rd_cnt = 0, sr_low = 0;
    int         wen_cyc = 0, ren_cyc = 0, sv_first = 0, sv_last = 0;
    logic [11:0] wen_addr = 12'h000;
    logic [7:0]  wen_data = 8'h00;
    logic [7:0]  rd_sr = 8'h00;
    logic        sv_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_wen) begin
            wen_cnt  <= wen_cnt + 1;
            wen_cyc  <= cyc;
            wen_addr <= mem_addr;
            wen_data <= mem_wdata;
        end
        if (mem_ren) begin
            ren_cnt <= ren_cnt + 1;
            ren_cyc <= cyc;
        end
        if (svalid) begin
            if (!sv_prev) sv_first <= cyc;
            sv_last <= cyc;
            rd_cnt  <= rd_cnt + 1;
            rd_sr   <= {srdata, rd_sr[7:1]};
        end
        sv_prev <= svalid;
        if (!sready) sr_low <= sr_low + 1;
    end

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Stall lengths are inserted after the given bit index (-1 = none)
    task automatic send_frame(input logic mode, input logic [11:0] a, input logic [7:0] d,
                              input int a_st_after, input int a_st_len,
                              input int d_st_after, input int d_st_len, output int e0);
        e0 = 0;
        for (int i = 0; i < 12; i++) begin
            mvalid = 1'b1;
            smode  = (i == 0) ? mode : ~mode;
            swdata = a[i];
            @(posedge clk); #1;
            if (i == 0) e0 = cyc;
            if (i == a_st_after) begin
                repeat (a_st_len) begin
                    mvalid = 1'b0; swdata = ~swdata;
                    @(posedge clk); #1;
                end
            end
        end
        if (mode) begin
            for (int i = 0; i < 8; i++) begin
                mvalid = 1'b1;
                swdata = d[i];
                @(posedge clk); #1;
                if (i == d_st_after) begin
                    repeat (d_st_len) begin
                        mvalid = 1'b0; swdata = ~swdata;
                        @(posedge clk); #1;
                    end
                end
            end
        end
        mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({srdata, svalid, sready, mem_wen, mem_ren} !== 5'b00100 || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_values got sr=%b sv=%b rdy=%b wen=%b ren=%b addr=%h wd=%h exp 0 0 1 0 0 000 00",
                     srdata, svalid, sready, mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (sready !== 1'b1 || mem_wen !== 1'b0 || svalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b wen=%b sv=%b exp 1 0 0", sready, mem_wen, svalid);
        end
    endtask

    task automatic test_write();
        int e0, w0, r0, s0;
        w0 = wen_cnt; r0 = ren_cnt; s0 = sr_low;
        send_frame(1'b1, 12'h5A3, 8'hC7, -1, 0, -1, 0, e0);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (wen_cnt - w0 !== 1) begin errors++; $display("FAIL write_wen_count got %0d exp 1", wen_cnt - w0); end
        checks++;
        if (ren_cnt - r0 !== 0) begin errors++; $display("FAIL write_ren_count got %0d exp 0", ren_cnt - r0); end
        checks++;
        if (wen_addr !== 12'h5A3 || wen_data !== 8'hC7) begin
            errors++; $display("FAIL write_addr_data got %h/%h exp 5a3/c7", wen_addr, wen_data);
        end
        checks++;
        if (wen_cyc - e0 !== 19) begin errors++; $display("FAIL write_wen_timing got %0d exp 19", wen_cyc - e0); end
        checks++;
        if (sr_low - s0 !== 21) begin errors++; $display("FAIL write_sready_low got %0d exp 21", sr_low - s0); end
    endtask

    task automatic test_read();
        int e0, w0, r0, s0, n0;
        preload(12'h5A3, 8'h3C);
        w0 = wen_cnt; r0 = ren_cnt; s0 = sr_low; n0 = rd_cnt;
        send_frame(1'b0, 12'h5A3, 8'h00, -1, 0, -1, 0, e0);
        repeat (12) @(posedge clk); #1;
        checks++;
        if (ren_cnt - r0 !== 1 || wen_cnt - w0 !== 0) begin
            errors++; $display("FAIL read_strobes got ren=%0d wen=%0d exp 1 0", ren_cnt - r0, wen_cnt - w0);
        end
        checks++;
        if (ren_cyc - e0 !== 11) begin errors++; $display("FAIL read_ren_timing got %0d exp 11", ren_cyc - e0); end
        checks++;
        if (rd_cnt - n0 !== 8 || sv_first - e0 !== 13 || sv_last - sv_first !== 7) begin
            errors++;
            $display("FAIL read_svalid_window got n=%0d first=%0d span=%0d exp 8 13 7",
                     rd_cnt - n0, sv_first - e0, sv_last - sv_first);
        end
        checks++;
        if (rd_sr !== 8'h3C) begin errors++; $display("FAIL read_data got %h exp 3c", rd_sr); end
        checks++;
        if (sr_low - s0 !== 21) begin errors++; $display("FAIL read_sready_low got %0d exp 21", sr_low - s0); end
    endtask

    task automatic test_stall();
        int e0, w0, s0;
        w0 = wen_cnt; s0 = sr_low;
        send_frame(1'b1, 12'h001, 8'hFF, 4, 3, 2, 2, e0);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (wen_cnt - w0 !== 1 || wen_addr !== 12'h001 || wen_data !== 8'hFF) begin
            errors++;
            $display("FAIL stall_write got n=%0d %h/%h exp 1 001/ff", wen_cnt - w0, wen_addr, wen_data);
        end
        checks++;
        if (wen_cyc - e0 !== 24) begin errors++; $display("FAIL stall_wen_timing got %0d exp 24", wen_cyc - e0); end
        checks++;
        if (sr_low - s0 !== 26) begin errors++; $display("FAIL stall_sready_low got %0d exp 26", sr_low - s0); end
    endtask

    task automatic test_reset_midframe();
        int e0, w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        for (int i = 0; i < 6; i++) begin
            mvalid = 1'b1; smode = 1'b1; swdata = 1'b1;
            @(posedge clk); #1;
        end
        mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
        checks++;
        if (mem_addr !== 12'hFC0 || sready !== 1'b0) begin
            errors++; $display("FAIL partial_frame got addr=%h rdy=%b exp fc0 0", mem_addr, sready);
        end
        #2 rst = 1'b1;
        #2;
        checks++;
        if ({srdata, svalid, sready, mem_wen, mem_ren} !== 5'b00100 || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got sr=%b sv=%b rdy=%b wen=%b ren=%b addr=%h wd=%h exp 0 0 1 0 0 000 00",
                     srdata, svalid, sready, mem_wen, mem_ren, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk); #1;
        checks++;
        if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0) begin
            errors++; $display("FAIL reset_no_strobe got wen=%0d ren=%0d exp 0 0", wen_cnt - w0, ren_cnt - r0);
        end
        send_frame(1'b1, 12'h7FF, 8'h12, -1, 0, -1, 0, e0);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (wen_cnt - w0 !== 1 || wen_addr !== 12'h7FF || wen_data !== 8'h12 || wen_cyc - e0 !== 19) begin
            errors++;
            $display("FAIL post_reset_write got n=%0d %h/%h t=%0d exp 1 7ff/12 19",
                     wen_cnt - w0, wen_addr, wen_data, wen_cyc - e0);
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1, w0, r0, n0;
        preload(12'h123, 8'hA5);
        w0 = wen_cnt; r0 = ren_cnt; n0 = rd_cnt;
        send_frame(1'b0, 12'h123, 8'h00, -1, 0, -1, 0, e0);
        // bits offered through MEMRD..RDATA, including the edge that returns to IDLE
        for (int i = 0; i < 10; i++) begin
            mvalid = 1'b1; smode = 1'b1; swdata = i[0];
            @(posedge clk); #1;
        end
        send_frame(1'b1, 12'h2D6, 8'h5B, -1, 0, -1, 0, e1);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (rd_sr !== 8'hA5 || rd_cnt - n0 !== 8 || ren_cnt - r0 !== 1) begin
            errors++; $display("FAIL b2b_read got %h n=%0d ren=%0d exp a5 8 1", rd_sr, rd_cnt - n0, ren_cnt - r0);
        end
        checks++;
        if (wen_cnt - w0 !== 1 || wen_addr !== 12'h2D6 || wen_data !== 8'h5B) begin
            errors++; $display("FAIL b2b_write got n=%0d %h/%h exp 1 2d6/5b", wen_cnt - w0, wen_addr, wen_data);
        end
        checks++;
        if (wen_cyc - e1 !== 19) begin errors++; $display("FAIL b2b_write_timing got %0d exp 19", wen_cyc - e1); end
    endtask

    task automatic test_boundary();
        int e0;
        logic [11:0] addrs [2];
        logic [7:0]  datas [2];
        addrs[0] = 12'h000; datas[0] = 8'h00;
        addrs[1] = 12'hFFF; datas[1] = 8'hFF;
        preload(12'h000, 8'h55);
        preload(12'hFFF, 8'hAA);
        for (int k = 0; k < 2; k++) begin
            send_frame(1'b1, addrs[k], datas[k], -1, 0, -1, 0, e0);
            repeat (4) @(posedge clk); #1;
            checks++;
            if (wen_addr !== addrs[k] || wen_data !== datas[k]) begin
                errors++; $display("FAIL boundary_write%0d got %h/%h exp %h/%h", k, wen_addr, wen_data, addrs[k], datas[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            send_frame(1'b0, addrs[k], 8'h00, -1, 0, -1, 0, e0);
            repeat (12) @(posedge clk); #1;
            checks++;
            if (rd_sr !== datas[k]) begin
                errors++; $display("FAIL boundary_read%0d got %h exp %h", k, rd_sr, datas[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
